display_arbiter: RTL and testbench

//   Shares the single output_driver display path between three sources: a clear request,
//   the ALU result stream and the keypad operand-entry echo.

---
 rtl/display_arbiter_if.sv | 34 +++
 rtl/display_arbiter.sv | 130 +++++++++++++
 tb/tb_display_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/display_arbiter_if.sv
// Bundle of the three display sources and the output_driver handshake.
// master = arbiter side, slave = the surrounding sources/sink.
interface display_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_clear;
  logic [DATA_WIDTH-1:0] i_res_data;
  logic                  i_res_is_neg;
  logic                  i_res_error;
  logic                  i_res_valid;
  logic                  o_res_ready;
  logic [DATA_WIDTH-1:0] i_ent_data;
  logic                  i_ent_is_neg;
  logic                  i_ent_valid;
  logic                  o_ent_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_is_neg;
  logic                  o_error;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_busy;

  modport master (
    input  i_clear, i_res_data, i_res_is_neg, i_res_error, i_res_valid,
           i_ent_data, i_ent_is_neg, i_ent_valid, i_ready,
    output o_res_ready, o_ent_ready, o_data, o_data_is_neg, o_error, o_valid, o_busy
  );

  modport slave (
    output i_clear, i_res_data, i_res_is_neg, i_res_error, i_res_valid,
           i_ent_data, i_ent_is_neg, i_ent_valid, i_ready,
    input  o_res_ready, o_ent_ready, o_data, o_data_is_neg, o_error, o_valid, o_busy
  );
endinterface

// File: rtl/display_arbiter.sv
// Arbitrates clear / ALU result / keypad echo onto the single output_driver path,
// buffering the granted word and periodically re-sending it to self-heal the display.
module display_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  display_arbiter_if.master bus
);

  localparam bit      REFRESH_EN = (REFRESH_CYCLES > 0);
  localparam int      CW         = REFRESH_EN ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam int      REF_LAST_I = REFRESH_EN ? REFRESH_CYCLES - 1 : 0;
  localparam [CW-1:0] REF_LAST   = CW'(REF_LAST_I);
  localparam [CW-1:0] CNT_MAX    = '1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_neg;
  logic                  r_err;
  logic                  r_clear_pend;
  logic                  r_shown;
  logic [CW-1:0]         r_ref_cnt;

  logic w_clr_req;
  logic w_ld_clr, w_ld_res, w_ld_ent, w_refresh, w_cnt_en, w_done;
  logic w_res_ready, w_ent_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Priority: clear (live or pending) > ALU result > entry echo > refresh.
  always_comb begin
    w_state_nxt = r_state;
    w_res_ready = 1'b0;
    w_ent_ready = 1'b0;
    w_ld_clr    = 1'b0;
    w_ld_res    = 1'b0;
    w_ld_ent    = 1'b0;
    w_refresh   = 1'b0;
    w_cnt_en    = 1'b0;
    w_done      = 1'b0;
    w_clr_req   = bus.i_clear | r_clear_pend;
    case (r_state)
      S_IDLE: begin
        w_res_ready = ~w_clr_req;
        w_ent_ready = ~w_clr_req & ~bus.i_res_valid;
        if (w_clr_req) begin
          w_ld_clr    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (bus.i_res_valid) begin
          w_ld_res    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (bus.i_ent_valid) begin
          w_ld_ent    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (REFRESH_EN && r_shown) begin
          if (r_ref_cnt == REF_LAST) begin
            w_refresh   = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bus.i_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_neg  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_ld_clr) begin
      r_data <= '0;
      r_neg  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_ld_res) begin
      r_data <= bus.i_res_data;
      r_neg  <= bus.i_res_is_neg;
      r_err  <= bus.i_res_error;
    end else if (w_ld_ent) begin
      r_data <= bus.i_ent_data;
      r_neg  <= bus.i_ent_is_neg;
      r_err  <= 1'b0;
    end
  end

  // A clear seen while busy is remembered once; repeats collapse into it.
  always_ff @(posedge clk) begin
    if (rst)           r_clear_pend <= 1'b0;
    else if (w_ld_clr) r_clear_pend <= 1'b0;
    else if (bus.i_clear) r_clear_pend <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_shown <= 1'b0;
    else if (w_done) r_shown <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ref_cnt <= '0;
    else if (w_ld_clr || w_ld_res || w_ld_ent || w_refresh || w_done)
      r_ref_cnt <= '0;
    else if (w_cnt_en && r_ref_cnt != CNT_MAX)
      r_ref_cnt <= r_ref_cnt + 1'b1;
  end

  assign bus.o_res_ready   = w_res_ready;
  assign bus.o_ent_ready   = w_ent_ready;
  assign bus.o_data        = r_data;
  assign bus.o_data_is_neg = r_neg;
  assign bus.o_error       = r_err;
  assign bus.o_valid       = (r_state == S_ISSUE);
  assign bus.o_busy        = (r_state == S_ISSUE);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a short refresh period.
module tb_display_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   nv;
  int   n;

  display_arbiter_if #(.DATA_WIDTH(16)) bus ();

  display_arbiter #(.DATA_WIDTH(16), .REFRESH_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word();
    return {14'd0, bus.o_data_is_neg, bus.o_error, bus.o_data};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.i_clear = 0; bus.i_res_data = 0; bus.i_res_is_neg = 0; bus.i_res_error = 0;
    bus.i_res_valid = 0; bus.i_ent_data = 0; bus.i_ent_is_neg = 0; bus.i_ent_valid = 0;
    bus.i_ready = 0;
    step; step; rst = 0;

    // reset / idle, nothing shown yet so no refresh
    nv = 0;
    repeat (10) begin step; if (bus.o_valid) nv++; end
    chk("rst_valid", nv, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_word", word(), 0);
    chk("rst_res_rdy", bus.o_res_ready, 1);
    chk("rst_ent_rdy", bus.o_ent_ready, 1);

    // single ALU result
    bus.i_ready = 1;
    bus.i_res_valid = 1; bus.i_res_data = 16'h0123; bus.i_res_is_neg = 1;
    @(negedge clk);
    chk("res_rdy", bus.o_res_ready, 1);
    chk("res_ent_rdy", bus.o_ent_ready, 1'b0);
    step; bus.i_res_valid = 0;
    chk("res_valid", bus.o_valid, 1);
    chk("res_busy", bus.o_busy, 1);
    chk("res_word", word(), {14'd0, 1'b1, 1'b0, 16'h0123});
    chk("res_issue_rdy", bus.o_res_ready, 0);
    step;
    chk("res_done", bus.o_valid, 0);

    // res and ent together: res first, one idle cycle, then ent
    bus.i_res_valid = 1; bus.i_res_data = 16'h0A0A; bus.i_res_is_neg = 0; bus.i_res_error = 1;
    bus.i_ent_valid = 1; bus.i_ent_data = 16'h0042; bus.i_ent_is_neg = 0;
    @(negedge clk);
    chk("both_ent_rdy", bus.o_ent_ready, 0);
    chk("both_res_rdy", bus.o_res_ready, 1);
    step; bus.i_res_valid = 0; bus.i_res_error = 0;
    chk("both_res_word", word(), {14'd0, 1'b0, 1'b1, 16'h0A0A});
    @(negedge clk);
    chk("both_issue_ent_rdy", bus.o_ent_ready, 0);
    step;
    chk("both_gap", bus.o_valid, 0);
    @(negedge clk);
    chk("both_ent_rdy2", bus.o_ent_ready, 1);
    step; bus.i_ent_valid = 0;
    chk("both_ent_valid", bus.o_valid, 1);
    chk("both_ent_word", word(), {14'd0, 1'b0, 1'b0, 16'h0042});
    step;

    // stall 20 cycles with two clear pulses -> one clear afterwards
    bus.i_ready = 0;
    bus.i_res_valid = 1; bus.i_res_data = 16'h1111;
    step; bus.i_res_valid = 0;
    for (int i = 0; i < 20; i++) begin
      bus.i_clear = (i == 3 || i == 10);
      @(negedge clk);
      chk("hold", {bus.o_valid, bus.o_data, bus.o_res_ready, bus.o_ent_ready},
          {1'b1, 16'h1111, 1'b0, 1'b0});
      step;
    end
    bus.i_clear = 0;
    bus.i_ready = 1;
    step;
    chk("hold_exit", bus.o_valid, 0);
    @(negedge clk);
    chk("pend_res_rdy", bus.o_res_ready, 0);
    step;
    chk("pend_valid", bus.o_valid, 1);
    chk("pend_word", word(), 0);
    step;
    nv = 0;
    repeat (6) begin step; if (bus.o_valid) nv++; end
    chk("pend_once", nv, 0);

    // clear + res + ent simultaneously
    bus.i_clear = 1;
    bus.i_res_valid = 1; bus.i_res_data = 16'h0A5A; bus.i_res_is_neg = 1;
    bus.i_ent_valid = 1; bus.i_ent_data = 16'h0042;
    @(negedge clk);
    chk("tri_res_rdy", bus.o_res_ready, 0);
    chk("tri_ent_rdy", bus.o_ent_ready, 0);
    step; bus.i_clear = 0;
    chk("tri_clr_word", {bus.o_valid, word()}, {1'b1, 32'd0});
    step;
    @(negedge clk);
    chk("tri_res_rdy2", bus.o_res_ready, 1);
    step; bus.i_res_valid = 0;
    chk("tri_res_word", word(), {14'd0, 1'b1, 1'b0, 16'h0A5A});
    step;
    @(negedge clk);
    chk("tri_ent_rdy2", bus.o_ent_ready, 1);
    step; bus.i_ent_valid = 0;
    chk("tri_ent_word", word(), {14'd0, 1'b0, 1'b0, 16'h0042});
    step;

    // refresh after exactly 8 idle cycles, repeating
    bus.i_ent_valid = 1; bus.i_ent_data = 16'h0007;
    step; bus.i_ent_valid = 0;
    chk("ref_first", word(), {16'd0, 16'h0007});
    step;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!bus.o_valid && n < 50) begin n++; step; end
      chk("ref_gap", n, 8);
      chk("ref_word", word(), {16'd0, 16'h0007});
      step;
    end

    // request arriving on the expiry cycle beats refresh
    repeat (7) step;
    bus.i_res_valid = 1; bus.i_res_data = 16'h0055; bus.i_res_is_neg = 0;
    step; bus.i_res_valid = 0;
    chk("ref_vs_req", {bus.o_valid, word()}, {1'b1, 16'd0, 16'h0055});
    step;

    // reset mid-issue with a clear pending
    bus.i_ready = 0;
    bus.i_res_valid = 1; bus.i_res_data = 16'h0999;
    step; bus.i_res_valid = 0;
    bus.i_clear = 1;
    step; bus.i_clear = 0;
    rst = 1;
    step; rst = 0;
    chk("mid_rst_valid", bus.o_valid, 0);
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_word", word(), 0);
    bus.i_ready = 1;
    nv = 0;
    repeat (12) begin step; if (bus.o_valid) nv++; end
    chk("mid_rst_quiet", nv, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
